inst_feeder: RTL and testbench

INST_FEEDER -- requirements
Module: inst_feeder

---
 rtl/inst_feeder.sv | 162 ++++++++++++++++
 tb/tb_inst_feeder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_feeder.sv
// rtl/inst_feeder.sv - instruction store that feeds one word per processor completion
// Optional WAIT watchdog enabled by defining INST_FEEDER_TIMEOUT_EN.
module inst_feeder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_en,
  input  logic [7:0]  load_addr,
  input  logic [31:0] load_data,
  input  logic [8:0]  num_inst,
  input  logic        start,
  input  logic        out_valid,
  input  logic [31:0] inst_addr,
  output logic        in_valid,
  output logic [31:0] inst,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [8:0]  issued
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  localparam logic [1:0] ERR_TIMEOUT  = 2'd0;
  localparam logic [1:0] ERR_ALIGN    = 2'd1;
  localparam logic [1:0] ERR_RANGE    = 2'd2;
  localparam logic [1:0] ERR_OVERLAP  = 2'd3;

  state_t      state_q, state_d;
  logic [7:0]  addr_q, addr_d;
  logic [8:0]  issued_q, issued_d;
  logic [8:0]  num_q, num_d;
  logic [1:0]  err_code_q, err_code_d;
  logic [31:0] mem_q [256];

`ifdef INST_FEEDER_TIMEOUT_EN
  logic [9:0]  tmo_q, tmo_d;
`endif

  // Store is deliberately outside the reset domain so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (load_en && !busy) begin
      mem_q[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= 8'd0;
      issued_q   <= 9'd0;
      num_q      <= 9'd1;
      err_code_q <= 2'd0;
`ifdef INST_FEEDER_TIMEOUT_EN
      tmo_q      <= 10'd0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      issued_q   <= issued_d;
      num_q      <= num_d;
      err_code_q <= err_code_d;
`ifdef INST_FEEDER_TIMEOUT_EN
      tmo_q      <= tmo_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    issued_d   = issued_q;
    num_d      = num_q;
    err_code_d = err_code_q;
`ifdef INST_FEEDER_TIMEOUT_EN
    tmo_d      = tmo_q;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_ISSUE;
          addr_d     = 8'd0;
          issued_d   = 9'd0;
          num_d      = (num_inst == 9'd0) ? 9'd1 : num_inst;
          err_code_d = 2'd0;
        end
      end
      S_ISSUE: begin
        issued_d = issued_q + 9'd1;
`ifdef INST_FEEDER_TIMEOUT_EN
        tmo_d    = 10'd0;
`endif
        if (out_valid) begin
          state_d    = S_ERR;
          err_code_d = ERR_OVERLAP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // start is ignored here; only the completion strobe matters.
        if (out_valid) begin
          if (issued_q == num_q) begin
            state_d = S_DONE;
          end else if (inst_addr[1:0] != 2'b00) begin
            state_d    = S_ERR;
            err_code_d = ERR_ALIGN;
          end else if (|inst_addr[31:10]) begin
            state_d    = S_ERR;
            err_code_d = ERR_RANGE;
          end else begin
            state_d = S_ISSUE;
            addr_d  = inst_addr[9:2];
          end
        end
`ifdef INST_FEEDER_TIMEOUT_EN
        else begin
          tmo_d = tmo_q + 10'd1;
          if (tmo_d == 10'd1023) begin
            state_d    = S_ERR;
            err_code_d = ERR_TIMEOUT;
          end
        end
`endif
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    in_valid = 1'b0;
    inst     = 32'd0;
    busy     = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    case (state_q)
      S_ISSUE: begin
        in_valid = 1'b1;
        inst     = mem_q[addr_q];
        busy     = 1'b1;
      end
      S_WAIT:  busy = 1'b1;
      S_DONE:  done = 1'b1;
      S_ERR:   err  = 1'b1;
      default: begin
        in_valid = 1'b0;
      end
    endcase
  end

  assign err_code = err_code_q;
  assign issued   = issued_q;

endmodule

// File: tb/tb_inst_feeder.sv
// tb/tb_inst_feeder.sv - directed self-checking bench for inst_feeder
module tb_inst_feeder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_en;
  logic [7:0]  load_addr;
  logic [31:0] load_data;
  logic [8:0]  num_inst;
  logic        start;
  logic        out_valid;
  logic [31:0] inst_addr;
  logic        in_valid;
  logic [31:0] inst;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic [8:0]  issued;

  int n_cmp = 0;
  int n_bad = 0;

  inst_feeder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .num_inst  (num_inst),
    .start     (start),
    .out_valid (out_valid),
    .inst_addr (inst_addr),
    .in_valid  (in_valid),
    .inst      (inst),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_code  (err_code),
    .issued    (issued)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Reply three cycles after the current in_valid cycle; returns in the following cycle.
  task automatic reply(input logic [31:0] a);
    tick();
    tick();
    tick();
    out_valid = 1'b1;
    inst_addr = a;
    tick();
    out_valid = 1'b0;
  endtask

  task automatic quiet(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      seen = seen | in_valid;
    end
    chk(tag, seen, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; load_en = 1'b0; load_addr = 8'd0; load_data = 32'd0;
    num_inst = 9'd4; start = 1'b0; out_valid = 1'b0; inst_addr = 32'd0;
    tick();
    tick();
    chk("rst_in_valid", in_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_issued", issued, 9'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) begin
      load_en = 1'b1; load_addr = 8'(i); load_data = 32'(i + 1) * 32'h11;
      tick();
    end
    load_en = 1'b0;

    // Sequential run of four, with a load attempt while busy.
    num_inst = 9'd4;
    pulse_start();
    chk("t1_iv0", in_valid, 1'b1);
    chk("t1_inst0", inst, 32'h11);
    chk("t1_busy", busy, 1'b1);
    load_en = 1'b1; load_addr = 8'd0; load_data = 32'hDEAD;
    tick();
    chk("t1_wait_iv", in_valid, 1'b0);
    chk("t1_wait_inst", inst, 32'd0);
    chk("t1_wait_issued", issued, 9'd1);
    tick(); tick();
    out_valid = 1'b1; inst_addr = 32'h4;
    tick();
    out_valid = 1'b0; load_en = 1'b0;
    chk("t1_iv1", in_valid, 1'b1);
    chk("t1_inst1", inst, 32'h22);
    reply(32'h8);
    chk("t1_inst2", inst, 32'h33);
    reply(32'hC);
    chk("t1_inst3", inst, 32'h44);
    reply(32'h10);
    chk("t1_done", done, 1'b1);
    chk("t1_busy0", busy, 1'b0);
    chk("t1_issued", issued, 9'd4);
    chk("t1_iv_done", in_valid, 1'b0);
    out_valid = 1'b1;
    tick();
    out_valid = 1'b0;
    chk("t1_done_ignore_ov", done, 1'b1);

    // Load accepted in DONE; backward branch to word 0.
    load_en = 1'b1; load_addr = 8'd5; load_data = 32'h55;
    tick();
    load_en = 1'b0;
    num_inst = 9'd3;
    pulse_start();
    chk("t2_inst0", inst, 32'h11);
    chk("t2_done_clr", done, 1'b0);
    reply(32'h14);
    chk("t2_inst1", inst, 32'h55);
    reply(32'h0);
    chk("t2_iv2", in_valid, 1'b1);
    chk("t2_inst2", inst, 32'h11);
    reply(32'h4);
    chk("t2_done", done, 1'b1);
    chk("t2_issued", issued, 9'd3);

    // Misaligned then out-of-range reply.
    pulse_start();
    reply(32'h6);
    chk("t3_err", err, 1'b1);
    chk("t3_code1", err_code, 2'd1);
    chk("t3_busy", busy, 1'b0);
    quiet("t3_quiet", 5);
    chk("t3_err_held", err, 1'b1);
    pulse_start();
    chk("t3_err_clr", err, 1'b0);
    chk("t3_restart_inst", inst, 32'h11);
    reply(32'h400);
    chk("t3_code2", err_code, 2'd2);
    chk("t3_err2", err, 1'b1);

    // Completion strobe coincident with in_valid.
    pulse_start();
    chk("t4_iv", in_valid, 1'b1);
    out_valid = 1'b1;
    tick();
    out_valid = 1'b0;
    chk("t4_err", err, 1'b1);
    chk("t4_code3", err_code, 2'd3);

    // num_inst of zero behaves as one.
    num_inst = 9'd0;
    pulse_start();
    chk("t5_inst", inst, 32'h11);
    reply(32'h4);
    chk("t5_done", done, 1'b1);
    chk("t5_issued", issued, 9'd1);

    // start alongside out_valid in WAIT: start ignored.
    num_inst = 9'd2;
    pulse_start();
    tick(); tick(); tick();
    out_valid = 1'b1; start = 1'b1; inst_addr = 32'hC;
    tick();
    out_valid = 1'b0; start = 1'b0;
    chk("t6_inst", inst, 32'h44);
    chk("t6_issued", issued, 9'd1);

    // Asynchronous reset mid-WAIT, store retained.
    num_inst = 9'd4;
    tick(); tick(); tick();
    out_valid = 1'b1; inst_addr = 32'h10;
    tick();
    out_valid = 1'b0;
    pulse_start();
    tick();
    chk("t7_pre_busy", busy, 1'b1);
    chk("t7_pre_issued", issued, 9'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("t7_busy", busy, 1'b0);
    chk("t7_issued", issued, 9'd0);
    chk("t7_inst", inst, 32'd0);
    chk("t7_err_code", err_code, 2'd0);
    chk("t7_done", done, 1'b0);
    tick();
    rst_n = 1'b1;
    quiet("t7_quiet", 4);
    pulse_start();
    chk("t7_restart_inst", inst, 32'h11);

`ifdef INST_FEEDER_TIMEOUT_EN
    for (int i = 0; i < 1023; i++) tick();
    chk("t8_still_busy", busy, 1'b1);
    tick();
    chk("t8_err", err, 1'b1);
    chk("t8_code0", err_code, 2'd0);
`else
    for (int i = 0; i < 2000; i++) tick();
    chk("t8_busy", busy, 1'b1);
    chk("t8_no_err", err, 1'b0);
    chk("t8_iv", in_valid, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
